// File: rtl/bitmap_encoder_pkg.sv
// Shared definitions for the bitmap encoder and its companion one-hot decoder.
package bitmap_encoder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Ceiling log2 usable in constant expressions; returns at least 1 so a
    // two-bit vector still gets a one-bit code.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bitmap_encoder_if.sv
// Bitmap-in / code-out handshake bundle. code_last exists only when
// BITMAP_ENCODER_LAST_EN is defined.
interface bitmap_encoder_if
    import bitmap_encoder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    localparam int CODE_W = clog2(WIDTH);

    logic [WIDTH-1:0]  data;
    logic              data_valid;
    logic              data_ready;
    logic [CODE_W-1:0] code;
    logic              code_valid;
    logic              code_ready;
    logic              busy;
`ifdef BITMAP_ENCODER_LAST_EN
    logic              code_last;
`endif

    // master: event source plus code consumer; slave: the encoder itself
    modport master (
        output data, data_valid, code_ready,
`ifdef BITMAP_ENCODER_LAST_EN
        input  code_last,
`endif
        input  data_ready, code, code_valid, busy
    );

    modport slave (
        input  data, data_valid, code_ready,
`ifdef BITMAP_ENCODER_LAST_EN
        output code_last,
`endif
        output data_ready, code, code_valid, busy
    );

endinterface

// File: rtl/bitmap_encoder_lowest_set_encoder.sv
// Combinational lowest-set-bit encoder: binary index plus one-hot mask of the
// selected bit. An all-zero vector yields code 0 and an empty mask.
module lowest_set_encoder #(
    parameter int WIDTH  = 8,
    parameter int CODE_W = 3
) (
    input  logic [WIDTH-1:0]  vec,
    output logic [CODE_W-1:0] code,
    output logic [WIDTH-1:0]  mask
);

    logic found;

    always_comb begin
        code  = '0;
        mask  = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i] && !found) begin
                code    = CODE_W'(i);
                mask[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bitmap_encoder.sv
// Serialises a captured multi-hot vector into binary codes, lowest index first.
// Optional code_last output enabled by defining BITMAP_ENCODER_LAST_EN.
module bitmap_encoder
    import bitmap_encoder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    bitmap_encoder_if.slave   bus
);

    localparam int CODE_W = clog2(WIDTH);

    state_t            state_reg;
    logic [WIDTH-1:0]  pending_reg;
    logic              data_ready_reg;
    logic              code_valid_reg;

    logic [CODE_W-1:0] sel_code;
    logic [WIDTH-1:0]  sel_mask;
    logic [WIDTH-1:0]  pending_next;

    // Code depends only on the pending register, never on the input side.
    lowest_set_encoder #(
        .WIDTH  (WIDTH),
        .CODE_W (CODE_W)
    ) u_lowest_set (
        .vec  (pending_reg),
        .code (sel_code),
        .mask (sel_mask)
    );

    assign pending_next = pending_reg & ~sel_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            pending_reg    <= '0;
            data_ready_reg <= 1'b1;
            code_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.data_valid && data_ready_reg) begin
                        // An all-zero vector is consumed here and leaves us idle.
                        pending_reg <= bus.data;
                        if (|bus.data) begin
                            state_reg      <= EMIT;
                            data_ready_reg <= 1'b0;
                            code_valid_reg <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (code_valid_reg && bus.code_ready) begin
                        pending_reg <= pending_next;
                        if (pending_next == '0) begin
                            state_reg      <= IDLE;
                            data_ready_reg <= 1'b1;
                            code_valid_reg <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    data_ready_reg <= 1'b1;
                    code_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Held low throughout reset so no source handshakes against a reset block.
    assign bus.data_ready = data_ready_reg & rst_n;
    assign bus.code_valid = code_valid_reg;
    assign bus.code       = sel_code;
    assign bus.busy       = |pending_reg;

`ifdef BITMAP_ENCODER_LAST_EN
    // Final code when the selected bit is the only one left.
    assign bus.code_last = code_valid_reg && (pending_reg == sel_mask) && (|pending_reg);
`endif

endmodule

// File: doc/bitmap_encoder.md
# bitmap_encoder

- Converts a captured multi-hot bit vector into a stream of binary codes, one code per set bit, lowest index first.
- Exact inverse of the team's one-hot decoder: bit k set produces code k, so 8'b0000_0100 yields code 3'b010.
- Sits between event/request collection logic and any consumer of 3-bit codes; it serialises simultaneous events that the decoder side cannot represent at once.
- Both sides use valid/ready handshakes.

## Interface
- WIDTH, 8, vector width; power of two, 2..256. CODE_W = log2(WIDTH) is a derived localparam.
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- Data  in  WIDTH  multi-hot input vector
- data_valid  in  1  Data is valid
- data_ready  out  1  block can capture a vector
- Code  out  CODE_W  binary index of the current lowest pending bit
- code_valid  out  1  Code is valid
- code_ready  in  1  consumer accepts Code
- busy  out  1  pending vector non-zero
- code_last  out  1  only with BITMAP_ENCODER_LAST_EN; marks final code of a vector

## Operation
- Internal pending register, WIDTH bits, holds the bits not yet emitted.
- States:
  - IDLE: data_ready=1, code_valid=0.
  - EMIT: data_ready=0, code_valid=1.
- IDLE, data_valid&&data_ready: pending<=Data.
  - Data!=0: go to EMIT.
  - Data==0: vector is accepted and dropped; stay IDLE; no code is produced.
- EMIT: Code = index of the lowest set bit of pending.
  - Code is derived only from the pending register; there is no combinational path from Data, data_valid or code_ready to Code/code_valid.
- EMIT, code_valid&&code_ready: clear that bit in pending.
  - Remaining pending==0: go to IDLE.
  - Otherwise: stay in EMIT with the next code.
- code_ready low: Code and code_valid hold unchanged; no bit is cleared.
- busy = (pending!=0); busy equals (state==EMIT).
- Reset values: pending=0, state=IDLE, data_ready=1 (deasserted while rst_n low), code_valid=0, Code=0, busy=0, code_last=0.
- Reset mid-vector: remaining codes are discarded; code_valid drops asynchronously.

## Timing
- Capture at edge N → code_valid=1 from cycle N+1.
- Throughput: one code per cycle while code_ready is held high.
- A vector with k set bits takes k handshake cycles. Last handshake at edge M → data_ready=1 in cycle M+1.
- New data is never accepted in the same cycle as the last code handshake; bubble of exactly one cycle between vectors.
- 0xFF with code_ready held high: codes 0..7 on consecutive cycles N+1..N+8; data_ready high at N+9.
- data_valid while busy: ignored (data_ready=0); the source must hold Data.
- Zero vector: data_ready stays high, so back-to-back zero vectors are accepted every cycle.

## Configuration
- BITMAP_ENCODER_LAST_EN defined:
  - Adds output code_last = code_valid && (pending has exactly one bit set).
  - Asserted with the final code of each vector, including single-bit vectors.
- BITMAP_ENCODER_LAST_EN undefined:
  - Port and logic are absent.
  - All other behaviour is identical.

## Structure
- Shared package holds:
  - the state typedef (IDLE, EMIT);
  - a clog2 function for CODE_W;
  - the 8-bit default width constant, shared with the decoder.
- One sub-module: lowest_set_encoder.
  - Combinational WIDTH-to-CODE_W lowest-set-bit encoder.
  - Also outputs a one-hot mask of the selected bit, used for the clear.

## Test plan
- Reset, then Data=8'b0000_0100 with code_ready=1 → Code=3'b010 at N+1, code_valid for one cycle, data_ready back at N+2.
- Data=8'hFF, code_ready=1 → codes 0..7 on consecutive cycles. With LAST_EN, code_last only on code 7.
- Data=8'b1000_0001, code_ready low for 5 cycles → Code=0 held stable throughout; then code 7, then idle.
- Data=8'h00 → accepted; no code_valid; data_ready never drops; busy stays 0.
- Data=8'hA5, rst_n low after the second code → code_valid=0 immediately. After release: IDLE, pending=0, next vector handled normally.
- data_valid pulsed while in EMIT → input ignored; output codes match only the first vector.
